// File: rtl/output_buffer_pkg.sv
// Shared accelerator definitions: the output drain FSM states and the AXI burst encoding.
package output_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } drain_state_e;

  localparam logic [3:0] BURST_INCR = 4'b0001;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned cw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// AXI-style write channel bundle (address, data, response) between the output buffer and DRAM.
interface output_buffer_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);

  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [3:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic          bvalid;
  logic          bready;

  modport master (
    output awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/output_buffer_addr_gen.sv
// Output map base register, raster tile counters and per-row DRAM burst address.
module out_addr_gen
  import output_buffer_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned POX = 15,
  parameter int unsigned POY = 3,
  parameter int unsigned OW  = 112,
  parameter int unsigned OH  = 112
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        i_base,
  input  logic                 i_load,
  input  logic                 i_tile_adv,
  input  logic [cw(POY)-1:0]   i_row,
  output logic [AW-1:0]        o_awaddr,
  output logic                 o_last_tile
);

  localparam int unsigned TX_N = OW / POX;
  localparam int unsigned TY_N = OH / POY;
  localparam int unsigned TXW  = cw(TX_N);
  localparam int unsigned TYW  = cw(TY_N);
  localparam logic [TXW-1:0] TX_MAX = TXW'(TX_N - 1);
  localparam logic [TYW-1:0] TY_MAX = TYW'(TY_N - 1);

  logic [AW-1:0]  r_base;
  logic [TXW-1:0] r_tx;
  logic [TYW-1:0] r_ty;
  logic [AW-1:0]  w_line;
  logic [AW-1:0]  w_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_tx   <= '0;
      r_ty   <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_tx   <= '0;
      r_ty   <= '0;
    end else if (i_tile_adv) begin
      if (r_tx == TX_MAX) begin
        r_tx <= '0;
        r_ty <= (r_ty == TY_MAX) ? '0 : r_ty + 1'b1;
      end else begin
        r_tx <= r_tx + 1'b1;
      end
    end
  end

  // Full AW-bit arithmetic so large maps wrap only at the final truncation.
  always_comb begin
    w_line   = AW'(r_ty) * AW'(POY) + AW'(i_row);
    w_pix    = w_line * AW'(OW) + AW'(r_tx) * AW'(POX);
    o_awaddr = r_base + w_pix * AW'(DW / 8);
  end

  assign o_last_tile = (r_tx == TX_MAX) && (r_ty == TY_MAX);

endmodule

// File: rtl/output_buffer.sv
// Ping-pong tile buffer for PE results, drained row by row as INCR bursts to DRAM.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned POX = 15,
  parameter int unsigned POY = 3,
  parameter int unsigned OW  = 112,
  parameter int unsigned OH  = 112
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       result       [POY][POX],
  input  logic                result_valid [POY][POX],
  input  logic [AW-1:0]       init_addr,
  input  logic                init_addr_en,
  output_buffer_if.master     m_axi,
  output logic                mapend,
  output logic                overflow,
  output logic                busy
);

  localparam int unsigned ROWW = cw(POY);
  localparam int unsigned COLW = cw(POX);
  localparam logic [ROWW-1:0] ROW_MAX = ROWW'(POY - 1);
  localparam logic [COLW-1:0] COL_MAX = COLW'(POX - 1);

  logic [DW-1:0]   r_bank [2][POY][POX];
  logic [1:0]      r_full;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic            r_overflow;
  drain_state_e    r_state;
  logic [ROWW-1:0] r_row;
  logic [COLW-1:0] r_col;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_wlast;
  logic            r_bready;
  logic            r_mapend;

  logic            w_capture;
  logic            w_drop;
  logic            w_release;
  logic            w_load;
  logic            w_busy;
  logic            w_last_tile;
  logic [AW-1:0]   w_awaddr;
  logic            w_unused_valid;

  assign w_capture = result_valid[0][0] && !r_full[r_wr_ptr];
  assign w_drop    = result_valid[0][0] &&  r_full[r_wr_ptr];
  assign w_release = (r_state == RESP) && r_bready && m_axi.bvalid && (r_row == ROW_MAX);
  assign w_busy    = (|r_full) || (r_state != IDLE);
  assign w_load    = init_addr_en && !w_busy;

  // Only the [0][0] strobe qualifies a tile; the rest are accepted but ignored.
  always_comb begin
    w_unused_valid = 1'b0;
    for (int unsigned y = 0; y < POY; y++)
      for (int unsigned x = 0; x < POX; x++)
        w_unused_valid = w_unused_valid ^ result_valid[y][x];
  end

  always_ff @(posedge clk) begin
    if (w_capture)
      for (int unsigned y = 0; y < POY; y++)
        for (int unsigned x = 0; x < POX; x++)
          r_bank[r_wr_ptr][y][x] <= result[y][x];
  end

  // Capture and release always target different banks, so both may fire together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full     <= '0;
      r_wr_ptr   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_release)
        r_full[r_rd_ptr] <= 1'b0;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_mapend  <= 1'b0;
    end else begin
      r_mapend <= w_release && w_last_tile;
      if (w_load)
        r_row <= '0;
      unique case (r_state)
        IDLE: begin
          if (r_full[r_rd_ptr]) begin
            r_awvalid <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi.awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_col     <= '0;
            r_wlast   <= (POX == 1);
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (m_axi.wready) begin
            if (r_col == COL_MAX) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= RESP;
            end else begin
              r_col   <= r_col + 1'b1;
              r_wlast <= ((r_col + 1'b1) == COL_MAX);
            end
          end
        end
        RESP: begin
          if (m_axi.bvalid) begin
            r_bready <= 1'b0;
            if (r_row == ROW_MAX) begin
              r_row    <= '0;
              r_rd_ptr <= ~r_rd_ptr;
              r_state  <= IDLE;
            end else begin
              r_row     <= r_row + 1'b1;
              r_awvalid <= 1'b1;
              r_state   <= ADDR;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  out_addr_gen #(
    .DW  (DW),
    .AW  (AW),
    .POX (POX),
    .POY (POY),
    .OW  (OW),
    .OH  (OH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_base      (init_addr),
    .i_load      (w_load),
    .i_tile_adv  (w_release),
    .i_row       (r_row),
    .o_awaddr    (w_awaddr),
    .o_last_tile (w_last_tile)
  );

  // Address/data buses are qualified by their valids so every output is 0 during reset.
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_awvalid ? w_awaddr : '0;
  assign m_axi.awlen   = r_awvalid ? 8'(POX - 1) : '0;
  assign m_axi.awburst = r_awvalid ? BURST_INCR : '0;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = r_wvalid ? r_bank[r_rd_ptr][r_row][r_col] : '0;
  assign m_axi.wlast   = r_wlast;
  assign m_axi.bready  = r_bready;
  assign mapend        = r_mapend;
  assign overflow      = r_overflow;
  assign busy          = w_busy;

endmodule
